cardinal_nic: RTL and testbench
===============================

Name: cardinal_nic

Overview:
Network interface between the cardinal_processor data-memory port and the on-chip ring/mesh router. The processor addresses four NIC registers through its Mem_Addr/Data_Out/Data_In/DmemEn/DmemWrEn path. The NIC holds one 64-bit outbound packet and one 64-bit inbound packet. It runs a ready/valid handshake with the router on each channel, gated by the router's even/odd polarity.

Parameters:
DATA_W, 64, packet and processor data width
ADDR_W, 2, register select width
VC_BIT, 0, index of the virtual-channel bit inside a packet

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-low reset
addr  in  [0:1]  register select: 00 in-buffer, 01 in-status, 10 out-buffer, 11 out-status
d_in  in  [0:63]  processor write data (Data_Out)
d_out  out  [0:63]  processor read data (Data_In)
nicEn  in  1  access enable (DmemEn)
nicWrEn  in  1  write enable (DmemWrEn), valid only with nicEn
net_so  out  1  send valid to router
net_ro  in  1  router ready to accept
net_do  out  [0:63]  packet to router
net_polarity  in  1  router cycle polarity: 0 even, 1 odd
net_si  in  1  router send valid into NIC
net_ri  out  1  NIC ready to accept
net_di  in  [0:63]  packet from router

Behaviour:
- Reset: Reset sampled low at a rising edge clears in_buf, out_buf, in_full and out_full to 0. After reset: net_so=0, net_ri=1, net_do=0, d_out=0.
- Reset mid-transfer: any pending packet in either buffer is dropped. There is no partial state.
- Processor write:
  - Condition: nicEn & nicWrEn & addr==10 & !out_full at the edge.
  - Effect: out_buf<=d_in, out_full<=1.
  - A write while out_full=1 is ignored.
  - Writes to addresses 00, 01 and 11 are ignored.
- Processor read is combinational, same cycle, with zero latency, because the processor captures Data_In at the end of its EX/MEM stage.
  - Read condition: nicEn & !nicWrEn.
  - addr 00 -> in_buf. addr 01 -> {63'b0,in_full}. addr 10 -> out_buf. addr 11 -> {63'b0,out_full}.
  - Status flag sits at bit 63 (LSB).
  - d_out=0 when no read is active.
- Read of addr 00 with in_full=1 clears in_full at that edge. in_buf data is retained but stale.
- Read of addr 00 with in_full=0 returns in_buf and has no side effect.
- Outbound channel:
  - net_do=out_buf, continuously.
  - net_so = out_full & net_ro & (out_buf[VC_BIT]==net_polarity), combinational.
  - At an edge with net_so=1, out_full<=0.
  - A packet whose VC bit mismatches the polarity waits, at most one cycle when the router is ready.
- Inbound channel:
  - net_ri = !in_full, registered state only.
  - At an edge with net_si & net_ri: in_buf<=net_di, in_full<=1.
  - net_si while net_ri=0 is a router protocol violation. The NIC ignores it and does not overwrite.
- Simultaneous events:
  - Processor write to 10 in the same cycle net_so fires: the write is ignored, because out_full was 1 at the start of the cycle. Software must poll 11 again.
  - Processor read of 00 in the same cycle the router presents net_si: net_ri=0 in that cycle, so no capture. The next cycle has net_ri=1. This gives single-entry throughput of one packet per two cycles per channel.
- Back-to-back sends: a write at edge N makes net_so eligible in cycle N+1. Out_full clears at the send edge. The next write is accepted one cycle later.

Decomposition:
- Shared package cardinal_nic_pkg holds:
  - address constants NIC_IN_BUF=2'b00, NIC_IN_STAT=2'b01, NIC_OUT_BUF=2'b10, NIC_OUT_STAT=2'b11;
  - DATA_W;
  - VC_BIT.
- One natural sub-module, nic_chan_buf: a one-entry 64-bit buffer with full flag, with push (load) and pop (clear) inputs and active-low synchronous reset.
  - Instantiated twice: the inbound copy pushes on net_si&net_ri and pops on the processor read of 00; the outbound copy pushes on the processor write to 10 and pops on net_so.
- Top level holds the read mux, net_so gating and decode.

Test Plan:
- Reset: drive Reset=0 for 2 edges with net_si=1 -> net_ri=1, net_so=0, net_do=0, d_out=0. Read 01 and 11 after release -> 0 and 0.
- Send with polarity wait:
  - Stimulus: write 10 with 64'h0123_4567_89AB_CDEF (VC bit 0), net_ro=1, net_polarity toggling starting at 1.
  - Expected: net_so=0 in the polarity=1 cycle, net_so=1 with net_do=0123_4567_89AB_CDEF in the next cycle. The read of 11 then returns 0.
- Write-while-full:
  - Stimulus: net_ro=0, write 10 with A=64'h1, then write 10 with B=64'h2.
  - Expected: read 10 returns 1 and status 11=1. After net_ro=1 with matching polarity, net_do=1 is sent once and B is never sent.
- Receive:
  - Stimulus: net_si=1 with net_di=64'hDEAD_BEEF_0000_0001.
  - Expected: next cycle net_ri=0 and read 01 returns 1. Read 00 returns DEAD_BEEF_0000_0001 in the same cycle, and net_ri=1 the following cycle.
- Receive back-pressure: hold net_si=1 with successive data values 5, 6 and no processor read -> in_buf stays 5 and net_ri=0. After the read of 00, value 6 is captured on the next accept edge.
- Mid-operation reset: with out_full=1 and in_full=1, assert Reset low for one edge -> both status reads return 0, net_so=0, net_ri=1, and the stale packet is never emitted.

Source files
------------

// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal_nic register map and packet format.
// Packet bit 0 is the MSB (big-endian numbering, as on the processor side).
package cardinal_nic_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 2;
    localparam int VC_BIT = 0;

    localparam logic [ADDR_W-1:0] NIC_IN_BUF   = 2'b00;
    localparam logic [ADDR_W-1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [ADDR_W-1:0] NIC_OUT_BUF  = 2'b10;
    localparam logic [ADDR_W-1:0] NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry packet buffer with a full flag. A push is only taken while
// empty; a pop only clears the flag, so the stored word stays readable.
module nic_chan_buf
    import cardinal_nic_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push,
    input  logic              pop,
    input  logic [0:DATA_W-1] d,
    output logic [0:DATA_W-1] q,
    output logic              full
);

    // NOTE: the stored word is reset as well as the flag, so the router
    // and the processor see zero after reset instead of a stale packet.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (push && !full) begin
            // NOTE: non-blocking so q and full both update from pre-edge values.
            q    <= d;
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// Network interface between the cardinal processor data-memory port and the
// router: register decode, zero-latency read mux and polarity-gated send.
module cardinal_nic
    import cardinal_nic_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [0:ADDR_W-1] addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di
);

    logic [0:DATA_W-1] in_buf;
    logic [0:DATA_W-1] out_buf;
    logic              in_full;
    logic              out_full;
    logic              rd_en;
    logic              rd_in_buf;
    logic              wr_out_buf;
    logic              in_push;

    assign rd_en      = nicEn & ~nicWrEn;
    assign rd_in_buf  = rd_en & (addr == NIC_IN_BUF);
    assign wr_out_buf = nicEn & nicWrEn & (addr == NIC_OUT_BUF);
    assign in_push    = net_si & net_ri;

    nic_chan_buf u_in_chan (
        .Clock (Clock),
        .Reset (Reset),
        .push  (in_push),
        .pop   (rd_in_buf),
        .d     (net_di),
        .q     (in_buf),
        .full  (in_full)
    );

    nic_chan_buf u_out_chan (
        .Clock (Clock),
        .Reset (Reset),
        .push  (wr_out_buf),
        .pop   (net_so),
        .d     (d_in),
        .q     (out_buf),
        .full  (out_full)
    );

    // Held low during reset so a packet being dropped cannot also be handed
    // to the router in the same cycle.
    assign net_so = Reset & out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
    assign net_do = out_buf;
    assign net_ri = ~in_full;

    // NOTE: default assignment first keeps this mux free of inferred latches.
    always_comb begin
        d_out = '0;
        if (rd_en) begin
            unique case (addr)
                NIC_IN_BUF:   d_out = in_buf;
                NIC_IN_STAT:  d_out = {{(DATA_W-1){1'b0}}, in_full};
                NIC_OUT_BUF:  d_out = out_buf;
                NIC_OUT_STAT: d_out = {{(DATA_W-1){1'b0}}, out_full};
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Scoreboard bench for cardinal_nic: directed scenarios then random traffic,
// checked against a queue-based model of the NIC's two single-entry channels.
module tb_cardinal_nic;
    import cardinal_nic_pkg::*;

    logic          Clock;
    logic          Reset;
    logic [0:1]    addr;
    logic [0:63]   d_in;
    logic [0:63]   d_out;
    logic          nicEn;
    logic          nicWrEn;
    logic          net_so;
    logic          net_ro;
    logic [0:63]   net_do;
    logic          net_polarity;
    logic          net_si;
    logic          net_ri;
    logic [0:63]   net_di;

    cardinal_nic dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        so;
        logic        ri;
        logic [0:63] dout;
    } cyc_t;

    cyc_t        cyc_q[$];
    logic [0:63] pkt_q[$];

    // Reference model: each channel is a queue holding at most one packet,
    // plus the last word ever loaded (what a read of the buffer address shows).
    logic [0:63] m_in_q[$];
    logic [0:63] m_out_q[$];
    logic [0:63] m_in_last;
    logic [0:63] m_out_last;

    int checks;
    int errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic wr,
                         input logic [1:0] a, input logic [0:63] din,
                         input logic ro, input logic pol,
                         input logic si, input logic [0:63] di);
        cyc_t e;
        logic send;
        logic acc_wr;
        logic acc_in;
        logic pop_in;
        Reset = rst; nicEn = en; nicWrEn = wr; addr = a; d_in = din;
        net_ro = ro; net_polarity = pol; net_si = si; net_di = di;

        send   = rst && (m_out_q.size() == 1) && ro && (m_out_q[0][VC_BIT] == pol);
        e.so   = send;
        e.ri   = (m_in_q.size() == 0);
        e.dout = '0;
        if (en && !wr) begin
            case (a)
                2'b00: e.dout = m_in_last;
                2'b01: e.dout = 64'(m_in_q.size());
                2'b10: e.dout = m_out_last;
                2'b11: e.dout = 64'(m_out_q.size());
            endcase
        end
        cyc_q.push_back(e);
        if (send) pkt_q.push_back(m_out_q[0]);

        if (!rst) begin
            m_in_q.delete();
            m_out_q.delete();
            m_in_last  = '0;
            m_out_last = '0;
        end else begin
            acc_wr = en && wr && (a == 2'b10) && (m_out_q.size() == 0);
            acc_in = si && (m_in_q.size() == 0);
            pop_in = en && !wr && (a == 2'b00) && (m_in_q.size() == 1);
            if (send)   void'(m_out_q.pop_front());
            if (pop_in) void'(m_in_q.pop_front());
            if (acc_in) begin
                m_in_q.push_back(di);
                m_in_last = di;
            end
            if (acc_wr) begin
                m_out_q.push_back(din);
                m_out_last = din;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    // Monitor: compares every presented cycle, and each emitted packet.
    always @(negedge Clock) begin : monitor
        cyc_t e;
        if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            check("net_so", 64'(net_so), 64'(e.so));
            check("net_ri", 64'(net_ri), 64'(e.ri));
            check("d_out", d_out, e.dout);
            if (net_so) begin
                if (pkt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL net_do: packet %h sent, none expected at %0t", net_do, $time);
                end else begin
                    check("net_do", net_do, pkt_q.pop_front());
                end
            end
        end
    end

    localparam logic [0:63] Z = '0;

    initial begin
        checks = 0;
        errors = 0;
        m_in_last  = '0;
        m_out_last = '0;
        Reset = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
        net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
        @(posedge Clock);
        #1;

        // Reset with the router pushing, then status reads.
        drive(0, 0, 0, 2'b00, Z, 0, 0, 1, 64'hFFFF_0000_FFFF_0000);
        drive(0, 0, 0, 2'b00, Z, 0, 0, 1, 64'hFFFF_0000_FFFF_0000);
        drive(1, 1, 0, 2'b01, Z, 0, 0, 0, Z);
        drive(1, 1, 0, 2'b11, Z, 0, 0, 0, Z);
        drive(1, 1, 0, 2'b00, Z, 0, 0, 0, Z);

        // Send with a polarity wait (VC bit 0, polarity 1 then 0).
        drive(1, 1, 1, 2'b10, 64'h0123_4567_89AB_CDEF, 1, 0, 0, Z);
        drive(1, 0, 0, 2'b00, Z, 1, 1, 0, Z);
        drive(1, 0, 0, 2'b00, Z, 1, 0, 0, Z);
        drive(1, 1, 0, 2'b11, Z, 1, 1, 0, Z);

        // Write while full: B must never be sent.
        drive(1, 1, 1, 2'b10, 64'h1, 0, 0, 0, Z);
        drive(1, 1, 1, 2'b10, 64'h2, 0, 0, 0, Z);
        drive(1, 1, 0, 2'b10, Z, 0, 0, 0, Z);
        drive(1, 1, 0, 2'b11, Z, 0, 0, 0, Z);
        drive(1, 0, 0, 2'b00, Z, 1, 0, 0, Z);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 2'b00, Z, 1, 1'(i), 0, Z);

        // Receive, then drain.
        drive(1, 0, 0, 2'b00, Z, 0, 0, 1, 64'hDEAD_BEEF_0000_0001);
        drive(1, 1, 0, 2'b01, Z, 0, 0, 0, Z);
        drive(1, 1, 0, 2'b00, Z, 0, 0, 0, Z);
        drive(1, 1, 0, 2'b01, Z, 0, 0, 0, Z);

        // Back-pressure: 6 is held off until after the read of 00.
        drive(1, 0, 0, 2'b00, Z, 0, 0, 1, 64'h5);
        drive(1, 0, 0, 2'b00, Z, 0, 0, 1, 64'h6);
        drive(1, 1, 0, 2'b00, Z, 0, 0, 1, 64'h6);
        drive(1, 0, 0, 2'b00, Z, 0, 0, 1, 64'h6);
        drive(1, 1, 0, 2'b00, Z, 0, 0, 0, Z);

        // Mid-operation reset with both buffers full and a ready router.
        drive(1, 1, 1, 2'b10, 64'h8000_0000_0000_00AA, 0, 0, 1, 64'h77);
        drive(0, 0, 0, 2'b00, Z, 1, 1, 0, Z);
        drive(1, 1, 0, 2'b01, Z, 1, 1, 0, Z);
        drive(1, 1, 0, 2'b11, Z, 1, 1, 0, Z);
        drive(1, 1, 0, 2'b10, Z, 1, 0, 0, Z);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  {$urandom(), $urandom()}, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {$urandom(), $urandom()});
        end

        drive(1, 0, 0, 2'b00, Z, 0, 0, 0, Z);
        @(posedge Clock);
        #1;
        check("pending packets", 64'(pkt_q.size()), 64'd0);
        check("unmonitored cycles", 64'(cyc_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
